video_driver: RTL and testbench
===============================

VIDEO_DRIVER -- requirements
Module: video_driver

Interface
REQ-001 SHALL have parameters H_SYNC=40, H_BACK=220, H_DISP=1280, H_FRONT=110, H_TOTAL=1650 (pixel clocks per line).
REQ-002 SHALL have parameters V_SYNC=5, V_BACK=20, V_DISP=720, V_FRONT=5, V_TOTAL=750 (lines per frame).
REQ-003 SHALL have parameter SYNC_POL=1'b0, the level of video_hs/video_vs during the sync pulse (0 = active-low).
REQ-004 pixel_clk  in  1  single clock; all state on rising edge.
REQ-005 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-006 pixel_data  in  24  RGB888 from the display source, valid the cycle after data_req.
REQ-007 data_req  out  1  request to the pixel source; pixel_xpos/pixel_ypos are valid while it is high.
REQ-008 pixel_xpos  out  11  column of the requested pixel, 0..H_DISP-1.
REQ-009 pixel_ypos  out  11  row of the requested pixel, 0..V_DISP-1.
REQ-010 video_hs  out  1  horizontal sync.
REQ-011 video_vs  out  1  vertical sync.
REQ-012 video_de  out  1  data enable, high in the active region.
REQ-013 video_rgb  out  24  output pixel.
REQ-014 frame_start  out  1  one-cycle pulse at the start of each frame.
REQ-015 frame_cnt  out  16  count of completed frames.

Function
REQ-016 cnt_h (11 bit) SHALL count 0..H_TOTAL-1 every cycle and wrap from H_TOTAL-1 to 0.
REQ-017 cnt_v (11 bit) SHALL advance only on the cycle cnt_h wraps, count 0..V_TOTAL-1, and wrap to 0 on the same edge that cnt_h wraps at cnt_v=V_TOTAL-1.
REQ-018 Define HA=H_SYNC+H_BACK (260) and VA=V_SYNC+V_BACK (25).
REQ-019 video_hs SHALL equal SYNC_POL when cnt_h<H_SYNC, else ~SYNC_POL.
REQ-020 video_vs SHALL equal SYNC_POL when cnt_v<V_SYNC (whole lines, aligned to cnt_h=0), else ~SYNC_POL.
REQ-021 video_de SHALL be high iff HA<=cnt_h<=HA+H_DISP-1 and VA<=cnt_v<=VA+V_DISP-1.
REQ-022 data_req SHALL be high iff HA-1<=cnt_h<=HA+H_DISP-2 and cnt_v is inside the vertical active range, so it leads video_de by exactly one cycle.
REQ-023 While data_req is high, pixel_xpos SHALL equal cnt_h-(HA-1) and pixel_ypos SHALL equal cnt_v-VA; otherwise both SHALL be 0.
REQ-024 video_rgb SHALL equal pixel_data when video_de=1, else 24'h000000; the source's one-cycle registered latency aligns with REQ-022.
REQ-025 frame_start SHALL be high for exactly one cycle, when cnt_h=0 and cnt_v=0.
REQ-026 frame_cnt SHALL increment by 1 on the cycle frame_start is high, except the first frame_start after reset, and SHALL wrap from 16'hFFFF to 0.
REQ-027 The first frame_start after reset SHALL be suppressed (no pulse, no count); it is the cycle immediately following reset release.
REQ-028 data_req, video_de, video_hs, video_vs and frame_start SHALL decode only from registered counters, with no dependence on pixel_data.
REQ-029 The counter arithmetic SHALL be 11-bit unsigned and SHALL never produce negative or out-of-range pixel_xpos or pixel_ypos.

Reset
REQ-030 Asserting sys_rst_n low SHALL immediately, without a clock, clear cnt_h, cnt_v and frame_cnt to 0.
REQ-031 During reset, data_req=0, video_de=0, pixel_xpos=0, pixel_ypos=0, video_rgb=0 and frame_start=0; video_hs and video_vs SHALL be at SYNC_POL, since the counters are 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame; after release, timing SHALL restart from cnt_h=0, cnt_v=0 with no partial-line glitch on data_req or video_de.

Verification
REQ-033 Release reset and count cycles -> video_hs is low for 40 cycles of every 1650; video_vs is low for 8250 cycles of every 1237500.
REQ-034 On line cnt_v=25 -> data_req rises at cnt_h=259 with pixel_xpos=0 and pixel_ypos=0; video_de rises at cnt_h=260; data_req falls after cnt_h=1538 (pixel_xpos=1279); video_de falls after cnt_h=1539.
REQ-035 Drive pixel_data=pixel_xpos registered by one cycle -> video_rgb[10:0] equals the column index 0..1279 across every active line, and is 0 in blanking.
REQ-036 Run 3 full frames -> frame_start pulses at cycles 1237500 and 2475000 after release; frame_cnt reads 1 then 2; no data_req outside lines 25..744.
REQ-037 Assert sys_rst_n low at cnt_v=400, cnt_h=900 for 3 cycles -> all outputs take their REQ-031 values asynchronously, frame_cnt=0, and the next data_req occurs 25*1650+259 cycles after release.
REQ-038 Force frame_cnt to 16'hFFFF via a sequence of frames or a preload in simulation, then complete one frame -> frame_cnt=0.

Source files
------------

// File: rtl/video_driver.sv
// Raster timing generator: line/frame counters, sync pulses, pixel requests
// and data-enable for a parallel RGB888 display port.
module video_driver #(
    parameter int H_SYNC   = 40,
    parameter int H_BACK   = 220,
    parameter int H_DISP   = 1280,
    parameter int H_FRONT  = 110,
    parameter int H_TOTAL  = 1650,
    parameter int V_SYNC   = 5,
    parameter int V_BACK   = 20,
    parameter int V_DISP   = 720,
    parameter int V_FRONT  = 5,
    parameter int V_TOTAL  = 750,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic        pixel_clk,
    input  logic        sys_rst_n,
    input  logic [23:0] pixel_data,
    output logic        data_req,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        video_hs,
    output logic        video_vs,
    output logic        video_de,
    output logic [23:0] video_rgb,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    localparam logic [10:0] HA    = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] VA    = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] HEND  = 11'(H_TOTAL - H_FRONT);
    localparam logic [10:0] VEND  = 11'(V_TOTAL - V_FRONT);
    localparam logic [10:0] HLAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] VLAST = 11'(V_TOTAL - 1);
    localparam logic [10:0] HSE   = 11'(H_SYNC);
    localparam logic [10:0] VSE   = 11'(V_SYNC);

    logic [10:0] cnt_h_q, cnt_h_d;
    logic [10:0] cnt_v_q, cnt_v_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        first_q;
    logic        h_act, h_req, v_act;

    always_comb begin
        cnt_h_d = cnt_h_q + 11'd1;
        cnt_v_d = cnt_v_q;
        if (cnt_h_q == HLAST) begin
            cnt_h_d = 11'd0;
            cnt_v_d = (cnt_v_q == VLAST) ? 11'd0 : cnt_v_q + 11'd1;
        end
    end

    // Request window opens one pixel early to cover the source's register stage.
    always_comb begin
        v_act = (cnt_v_q >= VA) && (cnt_v_q < VEND);
        h_act = (cnt_h_q >= HA) && (cnt_h_q < HEND);
        h_req = (cnt_h_q >= HA - 11'd1) && (cnt_h_q < HEND - 11'd1);
    end

    always_comb begin
        data_req    = v_act && h_req;
        video_de    = v_act && h_act;
        pixel_xpos  = data_req ? cnt_h_q - (HA - 11'd1) : 11'd0;
        pixel_ypos  = data_req ? cnt_v_q - VA : 11'd0;
        video_hs    = (cnt_h_q < HSE) ? SYNC_POL : ~SYNC_POL;
        video_vs    = (cnt_v_q < VSE) ? SYNC_POL : ~SYNC_POL;
        video_rgb   = video_de ? pixel_data : 24'h000000;
        // The origin seen right after reset release is not a frame boundary.
        frame_start = (cnt_h_q == 11'd0) && (cnt_v_q == 11'd0) && !first_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 16'd1 : frame_cnt_q;
        frame_cnt   = frame_cnt_q;
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h_q     <= 11'd0;
            cnt_v_q     <= 11'd0;
            frame_cnt_q <= 16'd0;
            first_q     <= 1'b1;
        end else begin
            cnt_h_q     <= cnt_h_d;
            cnt_v_q     <= cnt_v_d;
            frame_cnt_q <= frame_cnt_d;
            first_q     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_driver.sv
// Bench for video_driver on a reduced raster, checked cycle by cycle
// against an arithmetic model of the raster position.
module tb_video_driver;

    localparam int HS = 3, HB = 5, HD = 12, HF = 4, HT = 24;
    localparam int VS = 2, VB = 3, VD = 6, VF = 2, VT = 13;
    localparam int HA = HS + HB, VA = VS + VB, FR = HT * VT;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] pixel_data = 24'h0;
    logic        data_req, video_hs, video_vs, video_de, frame_start;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic [23:0] video_rgb;
    logic [15:0] frame_cnt;

    int          vec = 0;
    int          errs = 0;
    int          t = 0;
    logic [15:0] fc_exp = 16'h0;

    video_driver #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF), .V_TOTAL(VT),
        .SYNC_POL(1'b0)
    ) dut (
        .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pixel_data),
        .data_req(data_req), .pixel_xpos(pixel_xpos),
        .pixel_ypos(pixel_ypos), .video_hs(video_hs), .video_vs(video_vs),
        .video_de(video_de), .video_rgb(video_rgb),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Pixel source: registered column index, random upper bits.
    always @(posedge clk) begin
        logic [31:0] r;
        r = $urandom;
        pixel_data <= {r[12:0], data_req ? pixel_xpos : 11'h7FF};
    end

    task automatic adv();
        bit f;
        f = (t > 0) && (t % FR == 0);
        @(negedge clk);
        t++;
        if (f) fc_exp++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
        fc_exp = 16'h0;
        #1;
    endtask

    task automatic test_reset();
        int hold;
        #2;
        vec++; if (data_req !== 1'b0) begin errs++;
            $display("FAIL rst_req got %b want 0", data_req); end
        vec++; if (video_de !== 1'b0) begin errs++;
            $display("FAIL rst_de got %b want 0", video_de); end
        vec++; if ({video_hs, video_vs} !== 2'b00) begin errs++;
            $display("FAIL rst_sync got %b want 00", {video_hs, video_vs}); end
        vec++; if (frame_cnt !== 16'h0) begin errs++;
            $display("FAIL rst_fcnt got %h want 0", frame_cnt); end
        hold = $urandom_range(2, 6);
        repeat (hold) @(negedge clk);
        release_reset();
        vec++; if (frame_start !== 1'b0) begin errs++;
            $display("FAIL first_fs got %b want 0", frame_start); end
        vec++; if (video_rgb !== 24'h0) begin errs++;
            $display("FAIL first_rgb got %h want 0", video_rgb); end
    endtask

    task automatic test_timing(input int n);
        int h, v;
        bit vin, e_de, e_req, e_fs;
        logic [10:0] e_x, e_y;
        logic [23:0] e_rgb;
        for (int i = 0; i < n; i++) begin
            adv();
            h = t % HT;
            v = (t / HT) % VT;
            vin = (v >= VA) && (v < VA + VD);
            e_de = vin && (h >= HA) && (h < HA + HD);
            e_req = vin && (h >= HA - 1) && (h < HA + HD - 1);
            e_x = e_req ? 11'(h - (HA - 1)) : 11'd0;
            e_y = e_req ? 11'(v - VA) : 11'd0;
            e_fs = (t % FR == 0);
            e_rgb = e_de ? {pixel_data[23:11], 11'(h - HA)} : 24'h0;
            vec++; if (video_hs !== (h >= HS)) begin errs++;
                $display("FAIL hs t=%0d got %b want %b", t, video_hs, h >= HS); end
            vec++; if (video_vs !== (v >= VS)) begin errs++;
                $display("FAIL vs t=%0d got %b want %b", t, video_vs, v >= VS); end
            vec++; if (video_de !== e_de) begin errs++;
                $display("FAIL de t=%0d got %b want %b", t, video_de, e_de); end
            vec++; if (data_req !== e_req) begin errs++;
                $display("FAIL req t=%0d got %b want %b", t, data_req, e_req); end
            vec++; if ({pixel_xpos, pixel_ypos} !== {e_x, e_y}) begin errs++;
                $display("FAIL pos t=%0d got %0d,%0d want %0d,%0d",
                         t, pixel_xpos, pixel_ypos, e_x, e_y); end
            vec++; if (video_rgb !== e_rgb) begin errs++;
                $display("FAIL rgb t=%0d got %h want %h", t, video_rgb, e_rgb); end
            vec++; if (frame_start !== e_fs) begin errs++;
                $display("FAIL fs t=%0d got %b want %b", t, frame_start, e_fs); end
            vec++; if (frame_cnt !== fc_exp) begin errs++;
                $display("FAIL fcnt t=%0d got %0d want %0d", t, frame_cnt, fc_exp); end
        end
    endtask

    task automatic test_midframe_reset();
        int target, hold, bound;
        target = FR * (t / FR + 1) + (VA + 2) * HT + $urandom_range(HA, HA + HD - 2);
        while (t < target) adv();
        #2;
        rst_n = 1'b0;
        #1;
        vec++; if ({data_req, video_de, frame_start} !== 3'b000) begin errs++;
            $display("FAIL async_ctl got %b want 000",
                     {data_req, video_de, frame_start}); end
        vec++; if ({pixel_xpos, pixel_ypos} !== 22'h0) begin errs++;
            $display("FAIL async_pos got %0d,%0d want 0,0", pixel_xpos, pixel_ypos); end
        vec++; if (video_rgb !== 24'h0) begin errs++;
            $display("FAIL async_rgb got %h want 0", video_rgb); end
        vec++; if ({video_hs, video_vs} !== 2'b00) begin errs++;
            $display("FAIL async_sync got %b want 00", {video_hs, video_vs}); end
        vec++; if (frame_cnt !== 16'h0) begin errs++;
            $display("FAIL async_fcnt got %0d want 0", frame_cnt); end
        hold = $urandom_range(1, 4);
        repeat (hold) @(negedge clk);
        release_reset();
        bound = VA * HT + HA + 4;
        while (data_req !== 1'b1 && t < bound) begin
            vec++; if (video_de !== 1'b0) begin errs++;
                $display("FAIL early_de t=%0d got %b want 0", t, video_de); end
            adv();
        end
        vec++; if (t != VA * HT + HA - 1) begin errs++;
            $display("FAIL req_latency got %0d want %0d", t, VA * HT + HA - 1); end
    endtask

    task automatic test_wrap();
        while (t % FR == 0 || t % FR == 1) adv();
        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        fc_exp = 16'hFFFF;
        test_timing(FR - (t % FR) + 3);
        vec++; if (frame_cnt !== 16'h0000) begin errs++;
            $display("FAIL wrap got %h want 0000", frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_timing(3 * FR + 5);
        test_midframe_reset();
        test_timing(FR + 10);
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
